// File: rtl/int_ctrl_if.sv
// ---------------------------------------------------------------------------
// int_ctrl_if -- bundle between the pipeline and the trap/interrupt controller.
//
// Pipeline -> controller : id_ecall, id_ebreak, id_mret, inst_addr, ex_jump,
//                          ex_jump_addr, ext_int, csr_mtvec, csr_mepc,
//                          csr_mstatus, global_int_en
// Controller -> pipeline : int_we[2:0] (bit2 mepc, bit1 mcause, bit0 mstatus),
//                          int_mepc, int_mcause, int_mstatus, hold, int_jump,
//                          int_jump_addr, dbg_state (current FSM state)
//
// Handshake: there is no back-pressure. Every int_we bit and int_jump is a
// single-cycle strobe; its data is valid exactly in the cycle the strobe is
// high, and the pipeline must accept it in that cycle (it is stalled by hold).
//
// modport master : pipeline side
// modport slave  : int_ctrl side
// ---------------------------------------------------------------------------
interface int_ctrl_if;
  logic        id_ecall;
  logic        id_ebreak;
  logic        id_mret;
  logic [15:0] inst_addr;
  logic        ex_jump;
  logic [15:0] ex_jump_addr;
  logic        ext_int;
  logic [15:0] csr_mtvec;
  logic [15:0] csr_mepc;
  logic [15:0] csr_mstatus;
  logic        global_int_en;

  logic [2:0]  int_we;
  logic [15:0] int_mepc;
  logic [15:0] int_mcause;
  logic [15:0] int_mstatus;
  logic        hold;
  logic        int_jump;
  logic [15:0] int_jump_addr;
  logic [2:0]  dbg_state;

  modport master (
    output id_ecall, id_ebreak, id_mret, inst_addr, ex_jump, ex_jump_addr,
           ext_int, csr_mtvec, csr_mepc, csr_mstatus, global_int_en,
    input  int_we, int_mepc, int_mcause, int_mstatus, hold, int_jump,
           int_jump_addr, dbg_state
  );

  modport slave (
    input  id_ecall, id_ebreak, id_mret, inst_addr, ex_jump, ex_jump_addr,
           ext_int, csr_mtvec, csr_mepc, csr_mstatus, global_int_en,
    output int_we, int_mepc, int_mcause, int_mstatus, hold, int_jump,
           int_jump_addr, dbg_state
  );
endinterface

// File: rtl/int_ctrl.sv
// ---------------------------------------------------------------------------
// int_ctrl -- trap / interrupt sequencer.
//
// Detects ECALL, EBREAK, MRET and enabled external interrupts while idle,
// stalls the pipeline, writes mepc / mcause / mstatus one CSR per cycle and
// then redirects the PC for one cycle.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : int_ctrl_if.slave (all event, CSR and write-back signals)
//
// Build option: define INT_VECTORED_EN to enable vectored interrupt targets
// (csr_mtvec[0]=1 -> base + 4*cause[14:0] for interrupts). Without it every
// trap goes to the base address.
// ---------------------------------------------------------------------------
module int_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  int_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    W_MEPC    = 3'd1,
    W_MCAUSE  = 3'd2,
    W_MSTATUS = 3'd3,
    W_MRET    = 3'd4,
    JUMP      = 3'd5
  } state_e;

  localparam logic [15:0] CAUSE_ECALL  = 16'd11;
  localparam logic [15:0] CAUSE_EBREAK = 16'd3;
  localparam logic [15:0] CAUSE_EXTINT = 16'h800B;

  state_e      state_q, state_d;
  logic [15:0] cause_q, cause_d;
  logic [15:0] epc_q, epc_d;
  logic        mret_q, mret_d;  // JUMP targets mepc instead of the trap vector

  logic        int_req;
  logic [15:0] trap_base;
  logic [15:0] trap_target;
  logic [15:0] mstatus_trap;
  logic [15:0] mstatus_mret;
  logic        unused_bits;

  assign int_req   = bus.ext_int & bus.global_int_en;
  assign trap_base = {bus.csr_mtvec[15:2], 2'b00};

  // 4*cause[14:0] taken modulo 2^16 only keeps cause[13:0].
`ifdef INT_VECTORED_EN
  assign trap_target = (bus.csr_mtvec[0] && cause_q[15])
                       ? trap_base + {cause_q[13:0], 2'b00}
                       : trap_base;
`else
  assign trap_target = trap_base;
`endif

  assign unused_bits = ^{bus.csr_mtvec[1:0], cause_q[14]};

  // Trap entry: MPIE (bit7) <- MIE (bit3), MIE cleared.
  assign mstatus_trap = {bus.csr_mstatus[15:8], bus.csr_mstatus[3],
                         bus.csr_mstatus[6:4], 1'b0, bus.csr_mstatus[2:0]};
  // Return: MIE <- MPIE, MPIE set.
  assign mstatus_mret = {bus.csr_mstatus[15:8], 1'b1,
                         bus.csr_mstatus[6:4], bus.csr_mstatus[7],
                         bus.csr_mstatus[2:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cause_q <= '0;
      epc_q   <= '0;
      mret_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
      mret_q  <= mret_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    cause_d           = cause_q;
    epc_d             = epc_q;
    mret_d            = mret_q;
    bus.hold          = 1'b1;
    bus.int_we        = 3'b000;
    bus.int_mepc      = '0;
    bus.int_mcause    = '0;
    bus.int_mstatus   = '0;
    bus.int_jump      = 1'b0;
    bus.int_jump_addr = '0;

    case (state_q)
      IDLE: begin
        bus.hold = 1'b0;
        if (bus.id_ecall) begin
          bus.hold = 1'b1;
          cause_d  = CAUSE_ECALL;
          epc_d    = bus.inst_addr;
          mret_d   = 1'b0;
          state_d  = W_MEPC;
        end else if (bus.id_ebreak) begin
          bus.hold = 1'b1;
          cause_d  = CAUSE_EBREAK;
          epc_d    = bus.inst_addr;
          mret_d   = 1'b0;
          state_d  = W_MEPC;
        end else if (bus.id_mret) begin
          bus.hold = 1'b1;
          mret_d   = 1'b1;
          state_d  = W_MRET;
        end else if (int_req) begin
          // A taken jump in EX has not retired its target yet: resume there.
          bus.hold = 1'b1;
          cause_d  = CAUSE_EXTINT;
          epc_d    = bus.ex_jump ? bus.ex_jump_addr : bus.inst_addr + 16'd2;
          mret_d   = 1'b0;
          state_d  = W_MEPC;
        end
      end
      W_MEPC: begin
        bus.int_we   = 3'b100;
        bus.int_mepc = epc_q;
        state_d      = W_MCAUSE;
      end
      W_MCAUSE: begin
        bus.int_we     = 3'b010;
        bus.int_mcause = cause_q;
        state_d        = W_MSTATUS;
      end
      W_MSTATUS: begin
        bus.int_we      = 3'b001;
        bus.int_mstatus = mstatus_trap;
        state_d         = JUMP;
      end
      W_MRET: begin
        bus.int_we      = 3'b001;
        bus.int_mstatus = mstatus_mret;
        state_d         = JUMP;
      end
      JUMP: begin
        bus.int_jump      = 1'b1;
        bus.int_jump_addr = mret_q ? bus.csr_mepc : trap_target;
        state_d           = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_int_ctrl.sv
module tb_int_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  int_ctrl_if bus();

  int_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  // {hold, int_we, int_mepc, int_mcause, int_mstatus, int_jump, int_jump_addr}
  logic [68:0] exp_q[$];

  function automatic logic [68:0] w(input logic h, input logic [2:0] we,
                                    input logic [15:0] mepc, input logic [15:0] mcause,
                                    input logic [15:0] mst, input logic j,
                                    input logic [15:0] ja);
    return {h, we, mepc, mcause, mst, j, ja};
  endfunction

  task automatic push_idle();
    exp_q.push_back(w(1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0));
  endtask

  task automatic push_trap(input logic [15:0] epc, input logic [15:0] cause,
                           input logic [15:0] mst, input logic [15:0] ja);
    exp_q.push_back(w(1'b1, 3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0));
    exp_q.push_back(w(1'b1, 3'b100, epc,   16'h0, 16'h0, 1'b0, 16'h0));
    exp_q.push_back(w(1'b1, 3'b010, 16'h0, cause, 16'h0, 1'b0, 16'h0));
    exp_q.push_back(w(1'b1, 3'b001, 16'h0, 16'h0, mst,   1'b0, 16'h0));
    exp_q.push_back(w(1'b1, 3'b000, 16'h0, 16'h0, 16'h0, 1'b1, ja));
  endtask

  task automatic push_mret(input logic [15:0] mst, input logic [15:0] ja);
    exp_q.push_back(w(1'b1, 3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0));
    exp_q.push_back(w(1'b1, 3'b001, 16'h0, 16'h0, mst,   1'b0, 16'h0));
    exp_q.push_back(w(1'b1, 3'b000, 16'h0, 16'h0, 16'h0, 1'b1, ja));
  endtask

  // Samples on the falling edge, then advances to just after the next rising edge.
  task automatic step_check(input int n, input string name);
    logic [68:0] exp_w;
    logic [68:0] got_w;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      got_w = {bus.hold, bus.int_we, bus.int_mepc, bus.int_mcause,
               bus.int_mstatus, bus.int_jump, bus.int_jump_addr};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s: expected queue empty, got %h", name, got_w);
      end else begin
        exp_w = exp_q.pop_front();
        if (got_w !== exp_w) begin
          errors++;
          $display("FAIL %s step %0d: got h=%b we=%b mepc=%h mcause=%h mst=%h j=%b ja=%h, want h=%b we=%b mepc=%h mcause=%h mst=%h j=%b ja=%h",
                   name, i, got_w[68], got_w[67:65], got_w[64:49], got_w[48:33],
                   got_w[32:17], got_w[16], got_w[15:0],
                   exp_w[68], exp_w[67:65], exp_w[64:49], exp_w[48:33],
                   exp_w[32:17], exp_w[16], exp_w[15:0]);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- driver ----------------
  task automatic clear_events();
    bus.id_ecall  = 1'b0;
    bus.id_ebreak = 1'b0;
    bus.id_mret   = 1'b0;
    bus.ext_int   = 1'b0;
    bus.ex_jump   = 1'b0;
  endtask

  typedef struct {
    logic        ecall;
    logic        ebreak;
    logic        mret;
    logic        ext_int;
    logic        gie;
    logic        ex_jump;
    logic [15:0] inst;
    logic [15:0] jaddr_in;
    logic [15:0] mtvec;
    logic [15:0] mepc;
    logic [15:0] mstatus;
    int          kind;      // 0 = no event, 1 = trap, 2 = mret
    logic [15:0] e_epc;
    logic [15:0] e_cause;
    logic [15:0] e_mst;
    logic [15:0] e_jaddr;
  } vec_t;

`ifdef INT_VECTORED_EN
  localparam logic [15:0] VT_0101 = 16'h012C;
  localparam logic [15:0] VT_FFFD = 16'h0028;
`else
  localparam logic [15:0] VT_0101 = 16'h0100;
  localparam logic [15:0] VT_FFFD = 16'hFFFC;
`endif

  vec_t vecs[11];

  task automatic apply_vec(input vec_t v, input string name);
    bus.id_ecall      = v.ecall;
    bus.id_ebreak     = v.ebreak;
    bus.id_mret       = v.mret;
    bus.ext_int       = v.ext_int;
    bus.global_int_en = v.gie;
    bus.ex_jump       = v.ex_jump;
    bus.inst_addr     = v.inst;
    bus.ex_jump_addr  = v.jaddr_in;
    bus.csr_mtvec     = v.mtvec;
    bus.csr_mepc      = v.mepc;
    bus.csr_mstatus   = v.mstatus;
    case (v.kind)
      1:       push_trap(v.e_epc, v.e_cause, v.e_mst, v.e_jaddr);
      2:       push_mret(v.e_mst, v.e_jaddr);
      default: push_idle();
    endcase
    push_idle();
    step_check(1, name);
    clear_events();
    case (v.kind)
      1:       step_check(5, name);
      2:       step_check(3, name);
      default: step_check(1, name);
    endcase
  endtask

  // ---------------- test ----------------
  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    clear_events();
    bus.inst_addr     = 16'h0;
    bus.ex_jump_addr  = 16'h0;
    bus.csr_mtvec     = 16'h0;
    bus.csr_mepc      = 16'h0;
    bus.csr_mstatus   = 16'h0;
    bus.global_int_en = 1'b0;

    //          ec    eb    mr    ext   gie   exj   inst      jin       mtvec     mepc      mst       k  epc       cause     mst       jaddr
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000, 16'h0100, 16'h0000, 16'h0008, 1, 16'h0040, 16'h000B, 16'h0080, 16'h0100};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, 16'h0203, 16'h0000, 16'hF00F, 1, 16'h1234, 16'h0003, 16'hF087, 16'h0200};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0050, 16'h0200, 16'h0100, 16'h0000, 16'h0008, 1, 16'h0200, 16'h800B, 16'h0080, 16'h0100};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'hFFFE, 16'h0000, 16'h0101, 16'h0000, 16'h0088, 1, 16'h0000, 16'h800B, 16'h0080, VT_0101};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0060, 16'h0000, 16'h0100, 16'h0044, 16'h0080, 2, 16'h0000, 16'h0000, 16'h0088, 16'h0044};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0060, 16'h0000, 16'h0100, 16'hABCD, 16'h1234, 2, 16'h0000, 16'h0000, 16'h12B4, 16'hABCD};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0070, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0080, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 1, 16'h0080, 16'h000B, 16'h0000, 16'h0100};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0090, 16'h0000, 16'h0100, 16'h0000, 16'h0008, 1, 16'h0090, 16'h0003, 16'h0080, 16'h0100};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hFFFD, 16'h0000, 16'h0008, 1, 16'h0012, 16'h800B, 16'h0080, VT_FFFD};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0300, 16'h0000, 16'h0101, 16'h0000, 16'h0000, 1, 16'h0300, 16'h000B, 16'h0000, 16'h0100};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    push_idle();
    push_idle();
    step_check(2, "reset");
    rst_n = 1'b1;
    push_idle();
    step_check(1, "post_reset");

    // Table-driven vectors
    for (int i = 0; i < 11; i++) begin
      apply_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // ecall and ext_int together: ecall first, interrupt taken on return to IDLE
    bus.id_ecall      = 1'b1;
    bus.ext_int       = 1'b1;
    bus.global_int_en = 1'b1;
    bus.ex_jump       = 1'b0;
    bus.inst_addr     = 16'h0400;
    bus.csr_mtvec     = 16'h0100;
    bus.csr_mstatus   = 16'h0008;
    push_trap(16'h0400, 16'h000B, 16'h0080, 16'h0100);
    push_trap(16'h0402, 16'h800B, 16'h0080, 16'h0100);
    push_idle();
    step_check(1, "coincide");
    bus.id_ecall = 1'b0;
    step_check(5, "coincide");
    bus.ext_int = 1'b0;
    step_check(5, "coincide");

    // Reset while in W_MCAUSE: sequence aborts, no further strobes or jump
    bus.id_ecall  = 1'b1;
    bus.inst_addr = 16'h0040;
    exp_q.push_back(w(1'b1, 3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0));
    exp_q.push_back(w(1'b1, 3'b100, 16'h0040, 16'h0, 16'h0, 1'b0, 16'h0));
    exp_q.push_back(w(1'b1, 3'b010, 16'h0, 16'h000B, 16'h0, 1'b0, 16'h0));
    push_idle();
    push_idle();
    push_idle();
    step_check(1, "rst_mid");
    bus.id_ecall = 1'b0;
    step_check(1, "rst_mid");
    rst_n = 1'b0;
    step_check(1, "rst_mid");
    rst_n = 1'b1;
    step_check(3, "rst_mid");

    // Randomised masked-interrupt cycles: never any activity
    bus.global_int_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.ext_int   = 1'($urandom_range(0, 1));
      bus.inst_addr = 16'($urandom_range(0, 16'hFFFF));
      push_idle();
      step_check(1, "masked_rand");
    end
    clear_events();

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expected entries never compared, want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
